// File: rtl/mem_access_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
// Op encodings match the core's memory-stage op field.
package mem_access_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4,
        SW  = 3'd5,
        SB  = 3'd6,
        SH  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Unknown ops fall into the default branch and are rejected like misaligned ones.
    function automatic logic misaligned(mem_op_t op, logic [1:0] offset);
        case (op)
            LW, SW:       return offset != 2'b00;
            LH, LHU, SH:  return offset[0];
            LB, LBU, SB:  return 1'b0;
            default:      return 1'b1;
        endcase
    endfunction

    function automatic logic is_load(mem_op_t op);
        return (op == LW) || (op == LB) || (op == LBU) || (op == LH) || (op == LHU);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Core request/response and data RAM port bundle for mem_access_unit.
// master = core plus RAM environment, slave = the sequencer.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, data_readdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               data_address, data_read, data_write, data_writedata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, data_readdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               data_address, data_read, data_write, data_writedata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane extract/extend for loads and lane merge for stores.
// Purely combinational; offset is the byte offset within the word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] base_word,
    input  logic [31:0] lane_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rd_word[7:0];
        case (offset)
            2'd0:    byte_lane = rd_word[31:24];
            2'd1:    byte_lane = rd_word[23:16];
            2'd2:    byte_lane = rd_word[15:8];
            default: byte_lane = rd_word[7:0];
        endcase
        half_lane = offset[1] ? rd_word[15:0] : rd_word[31:16];

        load_data = 32'b0;
        case (op)
            LW:      load_data = rd_word;
            LB:      load_data = {{24{byte_lane[7]}}, byte_lane};
            LBU:     load_data = {24'b0, byte_lane};
            LH:      load_data = {{16{half_lane[15]}}, half_lane};
            LHU:     load_data = {16'b0, half_lane};
            default: load_data = 32'b0;
        endcase
    end

    always_comb begin
        store_word = base_word;
        case (op)
            SW: store_word = lane_data;
            SB: begin
                case (offset)
                    2'd0:    store_word[31:24] = lane_data[7:0];
                    2'd1:    store_word[23:16] = lane_data[7:0];
                    2'd2:    store_word[15:8]  = lane_data[7:0];
                    default: store_word[7:0]   = lane_data[7:0];
                endcase
            end
            SH: begin
                if (offset[1]) store_word[15:0]  = lane_data[15:0];
                else           store_word[31:16] = lane_data[15:0];
            end
            default: store_word = base_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: byte/half/word core accesses to a word-only data RAM.
// Sub-word stores are done as read-modify-write since the RAM lacks byte enables.
//
// state | meaning
// IDLE  | ready for a request, RAM port quiet
// RD    | one-cycle RAM read (load result or RMW merge base)
// WR    | one-cycle RAM write
// RESP  | one-cycle response pulse
module mem_access_unit
    import mem_access_pkg::*;
(
    input logic         clk,
    input logic         reset,
    mem_access_if.slave bus
);

    state_t      state, state_next;
    mem_op_t     op_q;
    mem_op_t     req_op_e;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
    logic        err_q;
    logic [31:0] load_data, store_word;

    assign req_op_e = mem_op_t'(bus.req_op);

    mem_lane_align u_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .rd_word    (bus.data_readdata),
        .base_word  (merge_q),
        .lane_data  (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= LW;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            merge_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= req_op_e;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= misaligned(req_op_e, bus.req_addr[1:0]);
                        rdata_q <= 32'b0;
                    end
                end
                RD: begin
                    if (is_load(op_q)) rdata_q <= load_data;
                    else               merge_q <= bus.data_readdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next         = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_err       = 1'b0;
        bus.resp_rdata     = 32'b0;
        bus.data_address   = 32'b0;
        bus.data_read      = 1'b0;
        bus.data_write     = 1'b0;
        bus.data_writedata = 32'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned(req_op_e, bus.req_addr[1:0])) state_next = RESP;
                    else if (req_op_e == SW)                     state_next = WR;
                    else                                         state_next = RD;
                end
            end
            RD: begin
                bus.data_read    = 1'b1;
                bus.data_address = {addr_q[31:2], 2'b00};
                state_next       = is_load(op_q) ? RESP : WR;
            end
            WR: begin
                bus.data_write     = 1'b1;
                bus.data_address   = {addr_q[31:2], 2'b00};
                bus.data_writedata = store_word;
                state_next         = RESP;
            end
            RESP: begin
                bus.resp_valid   = 1'b1;
                bus.resp_err     = err_q;
                bus.resp_rdata   = rdata_q;
                bus.data_address = {addr_q[31:2], 2'b00};
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences,
// and randomized accesses checked against a byte-level memory model.
module tb_mem_access_unit;

    localparam logic [2:0] T_LW = 3'd0, T_LB = 3'd1, T_LBU = 3'd2, T_LH = 3'd3,
                           T_LHU = 3'd4, T_SW = 3'd5, T_SB = 3'd6, T_SH = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_access_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge clk) begin
        if (bus.data_write)  ram[bus.data_address[9:2]] <= bus.data_writedata;
        else if (pl_we)      ram[pl_idx] <= pl_data;
    end
    assign bus.data_readdata = ram[bus.data_address[9:2]];

    int checks = 0;
    int errors = 0;
    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    function automatic logic model_err(input logic [2:0] op, input logic [31:0] addr);
        int size;
        size = (op == T_LW || op == T_SW) ? 4 : (op == T_LH || op == T_LHU || op == T_SH) ? 2 : 1;
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        int off;
        logic [31:0] b, h;
        off = int'(addr % 4);
        b = (word >> (24 - 8 * off)) & 32'hFF;
        h = (word >> (16 - 8 * off)) & 32'hFFFF;
        case (op)
            T_LW:    return word;
            T_LB:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            T_LBU:   return b;
            T_LH:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            T_LHU:   return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] op, input logic [31:0] addr,
                                                input logic [31:0] word, input logic [31:0] wdata);
        int sh;
        logic [31:0] mask;
        if (op == T_SW) return wdata;
        if (op == T_SB) begin
            sh = 24 - 8 * int'(addr % 4);
            mask = 32'hFF << sh;
            return (word & ~mask) | ((wdata & 32'hFF) << sh);
        end
        sh = 16 - 8 * int'(addr % 4);
        mask = 32'hFFFF << sh;
        return (word & ~mask) | ((wdata & 32'hFFFF) << sh);
    endfunction

    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output int nboth, output int nbad,
                          output logic extra_pulse);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs after acceptance; they must not matter
        bus.req_valid = 1'b0;
        bus.req_op = 3'($urandom_range(0, 7));
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = 0; nrd = 0; nwr = 0; nboth = 0; nbad = 0;
        rdata = 32'hBAD0_BAD0; err = 1'bx;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (bus.data_read && bus.data_write) nboth++;
            if (bus.data_read) nrd++;
            if (bus.data_write) nwr++;
            if ((bus.data_read || bus.data_write) && bus.data_address !== {addr[31:2], 2'b00}) nbad++;
            if (bus.resp_valid) begin
                lat = cyc; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        extra_pulse = bus.resp_valid;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat, input int exp_rd,
                                 input int exp_wr);
        logic [31:0] rdata;
        logic err, extra;
        int lat, nrd, nwr, nboth, nbad;
        do_txn(op, addr, wdata, rdata, err, lat, nrd, nwr, nboth, nbad, extra);
        check($sformatf("%s.latency", tag), lat, exp_lat);
        check($sformatf("%s.rdata", tag), rdata, exp_rdata);
        check($sformatf("%s.err", tag), {31'b0, err}, {31'b0, exp_err});
        check($sformatf("%s.read_cycles", tag), nrd, exp_rd);
        check($sformatf("%s.write_cycles", tag), nwr, exp_wr);
        check($sformatf("%s.rd_wr_overlap", tag), nboth, 0);
        check($sformatf("%s.address", tag), nbad, 0);
        check($sformatf("%s.single_pulse", tag), {31'b0, extra}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr, wdata, exp;
        logic        e;
        int          cnt;

        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        vecs[0]  = '{T_LB,  32'h12, 32'h0,        32'hFFFF_FFAA, 1'b0, 2, 1, 0};
        vecs[1]  = '{T_LBU, 32'h12, 32'h0,        32'h0000_00AA, 1'b0, 2, 1, 0};
        vecs[2]  = '{T_LH,  32'h10, 32'h0,        32'hFFFF_8899, 1'b0, 2, 1, 0};
        vecs[3]  = '{T_LHU, 32'h12, 32'h0,        32'h0000_AABB, 1'b0, 2, 1, 0};
        vecs[4]  = '{T_LB,  32'h13, 32'h0,        32'hFFFF_FFBB, 1'b0, 2, 1, 0};
        vecs[5]  = '{T_LHU, 32'h10, 32'h0,        32'h0000_8899, 1'b0, 2, 1, 0};
        vecs[6]  = '{T_SW,  32'h20, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1};
        vecs[7]  = '{T_LW,  32'h20, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0};
        vecs[8]  = '{T_SB,  32'h31, 32'h1234_56AB, 32'h0,        1'b0, 3, 1, 1};
        vecs[9]  = '{T_LW,  32'h30, 32'h0,        32'h11AB_3344, 1'b0, 2, 1, 0};
        vecs[10] = '{T_SH,  32'h32, 32'h9876_CDEF, 32'h0,        1'b0, 3, 1, 1};
        vecs[11] = '{T_LW,  32'h30, 32'h0,        32'h11AB_CDEF, 1'b0, 2, 1, 0};
        vecs[12] = '{T_LW,  32'h41, 32'h0,        32'h0,         1'b1, 1, 0, 0};
        vecs[13] = '{T_SH,  32'h43, 32'h0000_FFFF, 32'h0,        1'b1, 1, 0, 0};
        vecs[14] = '{T_LH,  32'h45, 32'h0,        32'h0,         1'b1, 1, 0, 0};
        vecs[15] = '{T_LBU, 32'h10, 32'h0,        32'h0000_0088, 1'b0, 2, 1, 0};

        // reset values
        @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst.resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst.resp_rdata", bus.resp_rdata, 32'd0);
        check("rst.data_address", bus.data_address, 32'd0);
        check("rst.strobes", {30'b0, bus.data_read, bus.data_write}, 32'd0);
        check("rst.data_writedata", bus.data_writedata, 32'd0);
        reset = 1'b0;

        preload(8'h04, 32'h8899_AABB);
        preload(8'h0C, 32'h1122_3344);
        preload(8'h10, 32'h5A5A_5A5A);
        preload(8'h11, 32'hA5A5_A5A5);

        for (int i = 0; i < 16; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat,
                          vecs[i].exp_rd, vecs[i].exp_wr);
        check("ram_0x20", ram[8'h08], 32'hDEAD_BEEF);
        check("ram_0x30", ram[8'h0C], 32'h11AB_CDEF);
        check("ram_0x40_untouched", ram[8'h10], 32'h5A5A_5A5A);
        check("ram_0x44_untouched", ram[8'h11], 32'hA5A5_A5A5);

        // reset during RD of an SB
        preload(8'h14, 32'hCAFE_F00D);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = T_SB; bus.req_addr = 32'h51; bus.req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst.in_rd", {31'b0, bus.data_read}, 32'd1);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("mid_rst.strobes", {30'b0, bus.data_read, bus.data_write}, 32'd0);
        check("mid_rst.data_address", bus.data_address, 32'd0);
        check("mid_rst.resp", {bus.resp_rdata[30:0], bus.resp_valid}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.data_write) cnt++;
        end
        check("mid_rst.no_resp", cnt, 0);
        check("mid_rst.ram", ram[8'h14], 32'hCAFE_F00D);

        // back-to-back with req_valid held high
        @(negedge clk);
        check("b2b.ready_idle0", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_op = T_SW; bus.req_addr = 32'h60; bus.req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("b2b.ready_wr", {31'b0, bus.req_ready}, 32'd0);
        check("b2b.write", {31'b0, bus.data_write}, 32'd1);
        @(negedge clk);
        check("b2b.ready_resp", {31'b0, bus.req_ready}, 32'd0);
        check("b2b.sw_resp", {30'b0, bus.resp_valid, bus.resp_err}, 32'd2);
        bus.req_op = T_LW;
        @(negedge clk);
        check("b2b.ready_idle1", {31'b0, bus.req_ready}, 32'd1);
        check("b2b.idle_quiet", {29'b0, bus.resp_valid, bus.data_read, bus.data_write}, 32'd0);
        @(negedge clk);
        check("b2b.ready_rd", {31'b0, bus.req_ready}, 32'd0);
        check("b2b.read", {31'b0, bus.data_read}, 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b.ready_resp2", {31'b0, bus.req_ready}, 32'd0);
        check("b2b.lw_valid", {31'b0, bus.resp_valid}, 32'd1);
        check("b2b.lw_rdata", bus.resp_rdata, 32'h0BAD_F00D);

        // randomized accesses against the memory model
        for (int w = 8'h20; w < 8'h30; w++) begin
            exp = $urandom;
            ref_mem[w] = exp;
            preload(8'(w), exp);
        end
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            addr = {24'h0, 2'b10, 6'($urandom_range(0, 63))};
            wdata = $urandom;
            e = model_err(op, addr);
            exp = 32'h0;
            if (!e && (op == T_SW || op == T_SB || op == T_SH))
                ref_mem[addr[9:2]] = model_store(op, addr, ref_mem[addr[9:2]], wdata);
            else if (!e)
                exp = model_load(op, addr, ref_mem[addr[9:2]]);
            run_and_check("rand", op, addr, wdata, exp, e,
                          e ? 1 : (op == T_SB || op == T_SH) ? 3 : 2,
                          (e || op == T_SW) ? 0 : 1,
                          (!e && (op == T_SW || op == T_SB || op == T_SH)) ? 1 : 0);
        end
        for (int w = 8'h20; w < 8'h30; w++)
            check($sformatf("rand.ram[%0h]", w), ram[w], ref_mem[w]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
